// File: rtl/calc2_pkg.sv
// Shared widths, command/response codes and issuer FSM states for the calc2 port logic.
package calc2_pkg;

  localparam int CMD_W       = 4;
  localparam int DATA_W      = 32;
  localparam int TAG_W       = 2;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE    = 2'd0,
    RESP_OK      = 2'd1,
    RESP_OVF_INV = 2'd2,
    RESP_ERR     = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND1 = 2'd1,
    ST_SEND2 = 2'd2
  } issue_state_e;

endpackage

// File: rtl/calc2_tag_tracker.sv
// Outstanding-tag bookkeeping: busy mask, per-tag age timers, lowest-free
// allocation, response matching and timeout arbitration.
module calc2_tag_tracker #(
  parameter int TAG_W   = calc2_pkg::TAG_W,
  parameter int TIMEOUT = calc2_pkg::TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic             resp_valid,
  input  logic [TAG_W-1:0] resp_tag,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             resp_hit,
  output logic             free_next,
  output logic             timeout_valid,
  output logic [TAG_W-1:0] timeout_tag,
  output logic [TAG_W:0]   outstanding
);

  localparam int NUM_TAGS = 2 ** TAG_W;
  localparam int TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [TMR_W-1:0]    timer_q [NUM_TAGS];
  logic [TMR_W-1:0]    timer_d [NUM_TAGS];
  logic                timeout_valid_q, timeout_valid_d;
  logic [TAG_W-1:0]    timeout_tag_q, timeout_tag_d;

  // Lowest-index free tag and response match, both from the registered busy mask.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_tag = TAG_W'(i);
    end
    resp_hit = resp_valid && busy_q[resp_tag];
  end

  // Pick the lowest expired tag not rescued by a response this cycle; others hold at TIMEOUT.
  always_comb begin
    timeout_valid_d = 1'b0;
    timeout_tag_d   = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (busy_q[i] && (timer_q[i] == TMR_MAX) &&
          !(resp_valid && (resp_tag == TAG_W'(i)))) begin
        timeout_valid_d = 1'b1;
        timeout_tag_d   = TAG_W'(i);
      end
    end
  end

  // Next busy mask and timers: age, free on response/timeout, claim on allocation.
  always_comb begin
    for (int i = 0; i < NUM_TAGS; i++) begin
      busy_d[i]  = busy_q[i];
      timer_d[i] = timer_q[i];
      if (busy_q[i] && (timer_q[i] != TMR_MAX)) timer_d[i] = timer_q[i] + TMR_W'(1);
      if (resp_hit && (resp_tag == TAG_W'(i))) begin
        busy_d[i]  = 1'b0;
        timer_d[i] = '0;
      end
      if (timeout_valid_d && (timeout_tag_d == TAG_W'(i))) begin
        busy_d[i]  = 1'b0;
        timer_d[i] = '0;
      end
      if (alloc_en && (alloc_tag == TAG_W'(i))) begin
        busy_d[i]  = 1'b1;
        timer_d[i] = '0;
      end
    end
    free_next = ~&busy_d;
  end

  // Popcount of the busy mask, so it moves in step with the mask itself.
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      outstanding = outstanding + (TAG_W + 1)'(busy_q[i]);
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q          <= '0;
      timeout_valid_q <= 1'b0;
      timeout_tag_q   <= '0;
      // NOTE: the timer array is only NUM_TAGS small registers, not a RAM, so it is reset explicitly.
      for (int i = 0; i < NUM_TAGS; i++) timer_q[i] <= '0;
    end else begin
      busy_q          <= busy_d;
      timeout_valid_q <= timeout_valid_d;
      timeout_tag_q   <= timeout_tag_d;
      timer_q         <= timer_d;
    end
  end

  assign timeout_valid = timeout_valid_q;
  assign timeout_tag   = timeout_tag_q;

endmodule

// File: rtl/calc2_port_issuer.sv
// Request issuer for one calc2 port: accepts whole operations, sends them as
// two request beats under a free tag, and reports completions and errors.
module calc2_port_issuer #(
  parameter int DATA_W  = calc2_pkg::DATA_W,
  parameter int CMD_W   = calc2_pkg::CMD_W,
  parameter int TAG_W   = calc2_pkg::TAG_W,
  parameter int TIMEOUT = calc2_pkg::TIMEOUT_DEF
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [CMD_W-1:0]  op_cmd,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [CMD_W-1:0]  req_cmd_in,
  output logic [DATA_W-1:0] req_data_in,
  output logic [TAG_W-1:0]  req_tag_in,
  input  logic [1:0]        out_resp,
  input  logic [DATA_W-1:0] out_data,
  input  logic [TAG_W-1:0]  out_tag,
  output logic              done_valid,
  output logic [1:0]        done_resp,
  output logic [DATA_W-1:0] done_data,
  output logic [TAG_W-1:0]  done_tag,
  output logic              timeout_valid,
  output logic [TAG_W-1:0]  timeout_tag,
  output logic              spurious_err,
  output logic [TAG_W:0]    outstanding
);

  import calc2_pkg::*;

  issue_state_e      state_q, state_d;
  logic              op_ready_q, op_ready_d;
  logic [CMD_W-1:0]  req_cmd_q, req_cmd_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              done_valid_q, done_valid_d;
  logic [1:0]        done_resp_q, done_resp_d;
  logic [DATA_W-1:0] done_data_q, done_data_d;
  logic [TAG_W-1:0]  done_tag_q, done_tag_d;
  logic              spurious_q, spurious_d;

  logic              accept;
  logic              resp_valid;
  logic              resp_hit;
  logic              free_next;
  logic [TAG_W-1:0]  alloc_tag;

  assign accept     = op_valid && op_ready_q;
  assign resp_valid = (out_resp != RESP_NONE);

  calc2_tag_tracker #(
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) u_tracker (
    .clk           (c_clk),
    .reset         (reset),
    .alloc_en      (accept),
    .resp_valid    (resp_valid),
    .resp_tag      (out_tag),
    .alloc_tag     (alloc_tag),
    .resp_hit      (resp_hit),
    .free_next     (free_next),
    .timeout_valid (timeout_valid),
    .timeout_tag   (timeout_tag),
    .outstanding   (outstanding)
  );

  // FSM next state and next request beat; cmd and A go straight into the first beat,
  // B and the tag are held for the second.
  always_comb begin
    state_d    = state_q;
    req_cmd_d  = '0;
    req_data_d = '0;
    req_tag_d  = '0;
    op_b_d     = op_b_q;
    tag_d      = tag_q;
    case (state_q)
      ST_SEND1: begin
        state_d    = ST_SEND2;
        req_data_d = op_b_q;
        req_tag_d  = tag_q;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d    = ST_SEND1;
      req_cmd_d  = op_cmd;
      req_data_d = op_a;
      req_tag_d  = alloc_tag;
      op_b_d     = op_b;
      tag_d      = alloc_tag;
    end
    // Registered ready: the state and free mask it will see next cycle.
    op_ready_d = ((state_d == ST_IDLE) || (state_d == ST_SEND2)) && free_next;
  end

  // Classify an incoming response as a completion or a spurious tag.
  always_comb begin
    done_valid_d = resp_hit;
    done_resp_d  = resp_hit ? out_resp : 2'd0;
    done_data_d  = resp_hit ? out_data : '0;
    done_tag_d   = resp_hit ? out_tag  : '0;
    spurious_d   = resp_valid && !resp_hit;
  end

  // FSM state and all registered outputs.
  always_ff @(posedge c_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= ST_IDLE;
      op_ready_q   <= 1'b0;
      req_cmd_q    <= '0;
      req_data_q   <= '0;
      req_tag_q    <= '0;
      op_b_q       <= '0;
      tag_q        <= '0;
      done_valid_q <= 1'b0;
      done_resp_q  <= '0;
      done_data_q  <= '0;
      done_tag_q   <= '0;
      spurious_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_ready_q   <= op_ready_d;
      req_cmd_q    <= req_cmd_d;
      req_data_q   <= req_data_d;
      req_tag_q    <= req_tag_d;
      op_b_q       <= op_b_d;
      tag_q        <= tag_d;
      done_valid_q <= done_valid_d;
      done_resp_q  <= done_resp_d;
      done_data_q  <= done_data_d;
      done_tag_q   <= done_tag_d;
      spurious_q   <= spurious_d;
    end
  end

  assign op_ready     = op_ready_q;
  assign req_cmd_in   = req_cmd_q;
  assign req_data_in  = req_data_q;
  assign req_tag_in   = req_tag_q;
  assign done_valid   = done_valid_q;
  assign done_resp    = done_resp_q;
  assign done_data    = done_data_q;
  assign done_tag     = done_tag_q;
  assign spurious_err = spurious_q;

endmodule

// File: tb/tb_calc2_port_issuer.sv
// Scoreboard bench for calc2_port_issuer: request beats, completions, timeouts
// and spurious pulses are queued with their due cycle and checked on arrival.
module tb_calc2_port_issuer;

  localparam int T = 16;

  logic        c_clk;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_cmd;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic [31:0] done_data;
  logic [1:0]  done_tag;
  logic        timeout_valid;
  logic [1:0]  timeout_tag;
  logic        spurious_err;
  logic [2:0]  outstanding;

  calc2_port_issuer #(
    .DATA_W (32), .CMD_W (4), .TAG_W (2), .TIMEOUT (T)
  ) dut (
    .c_clk (c_clk), .reset (reset),
    .op_valid (op_valid), .op_ready (op_ready),
    .op_cmd (op_cmd), .op_a (op_a), .op_b (op_b),
    .req_cmd_in (req_cmd_in), .req_data_in (req_data_in), .req_tag_in (req_tag_in),
    .out_resp (out_resp), .out_data (out_data), .out_tag (out_tag),
    .done_valid (done_valid), .done_resp (done_resp), .done_data (done_data), .done_tag (done_tag),
    .timeout_valid (timeout_valid), .timeout_tag (timeout_tag),
    .spurious_err (spurious_err), .outstanding (outstanding)
  );

  typedef struct { int due; logic [3:0] cmd; logic [31:0] data; logic [1:0] tag; } beat_t;
  typedef struct { int due; logic [1:0] resp; logic [31:0] data; logic [1:0] tag; } done_t;
  typedef struct { int due; logic [1:0] tag; } tmo_t;

  beat_t req_q[$];
  done_t done_q[$];
  tmo_t  tmo_q[$];
  int    spur_q[$];

  int       n_checks = 0;
  int       n_pass   = 0;
  int       cyc      = 0;
  bit [3:0] model_busy = '0;

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  // Scoreboard monitor: compares each due event and flags any unexpected pulse.
  always @(negedge c_clk) begin : mon
    beat_t b;
    done_t d;
    tmo_t  t;
    bit    exp_p;
    if (req_q.size() > 0 && req_q[0].due == cyc) begin
      b = req_q.pop_front();
      n_checks++;
      if ({req_cmd_in, req_data_in, req_tag_in} !== {b.cmd, b.data, b.tag})
        $display("FAIL req_beat cyc=%0d got cmd=%h data=%h tag=%0d want cmd=%h data=%h tag=%0d",
                 cyc, req_cmd_in, req_data_in, req_tag_in, b.cmd, b.data, b.tag);
      else n_pass++;
    end
    exp_p = (done_q.size() > 0 && done_q[0].due == cyc);
    if (exp_p || done_valid !== 1'b0) begin
      n_checks++;
      if (!exp_p) $display("FAIL done_unexpected cyc=%0d got done_valid=%b tag=%0d want no completion", cyc, done_valid, done_tag);
      else begin
        d = done_q.pop_front();
        if ({done_valid, done_resp, done_data, done_tag} !== {1'b1, d.resp, d.data, d.tag})
          $display("FAIL done cyc=%0d got v=%b resp=%0d data=%h tag=%0d want v=1 resp=%0d data=%h tag=%0d",
                   cyc, done_valid, done_resp, done_data, done_tag, d.resp, d.data, d.tag);
        else n_pass++;
      end
    end
    exp_p = (tmo_q.size() > 0 && tmo_q[0].due == cyc);
    if (exp_p || timeout_valid !== 1'b0) begin
      n_checks++;
      if (!exp_p) $display("FAIL timeout_unexpected cyc=%0d got timeout_valid=%b tag=%0d want none", cyc, timeout_valid, timeout_tag);
      else begin
        t = tmo_q.pop_front();
        if ({timeout_valid, timeout_tag} !== {1'b1, t.tag})
          $display("FAIL timeout cyc=%0d got v=%b tag=%0d want v=1 tag=%0d", cyc, timeout_valid, timeout_tag, t.tag);
        else n_pass++;
      end
    end
    exp_p = (spur_q.size() > 0 && spur_q[0] == cyc);
    if (exp_p || spurious_err !== 1'b0) begin
      n_checks++;
      if (!exp_p) $display("FAIL spurious_unexpected cyc=%0d got spurious_err=%b want 0", cyc, spurious_err);
      else begin
        void'(spur_q.pop_front());
        if (spurious_err !== 1'b1) $display("FAIL spurious cyc=%0d got spurious_err=%b want 1", cyc, spurious_err);
        else n_pass++;
      end
    end
  end

  function automatic logic [1:0] lowest_free();
    logic [1:0] r = 2'd0;
    for (int i = 3; i >= 0; i--) if (!model_busy[i]) r = 2'(i);
    return r;
  endfunction

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge c_clk);
  endtask

  // Offer one op; returns its expected tag and the cycle at which SEND1 is visible.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       output logic [1:0] tag, output int s1_cyc);
    int guard = 0;
    op_valid = 1'b1; op_cmd = cmd; op_a = a; op_b = b;
    while (op_ready !== 1'b1 && guard < 50) begin
      @(negedge c_clk);
      guard++;
    end
    tag = 2'd0;
    if (op_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL issue_wait got op_ready=%b after %0d cycles want 1", op_ready, guard);
      op_valid = 1'b0;
      s1_cyc = cyc;
      return;
    end
    tag = lowest_free();
    model_busy[tag] = 1'b1;
    req_q.push_back('{due: cyc + 1, cmd: cmd,  data: a, tag: tag});
    req_q.push_back('{due: cyc + 2, cmd: 4'd0, data: b, tag: tag});
    @(negedge c_clk);
    op_valid = 1'b0;
    s1_cyc = cyc;
  endtask

  // Drive one response cycle; expectation depends on whether the model holds the tag.
  task automatic respond(input logic [1:0] resp, input logic [31:0] data, input logic [1:0] tag);
    out_resp = resp; out_data = data; out_tag = tag;
    if (model_busy[tag]) begin
      done_q.push_back('{due: cyc + 1, resp: resp, data: data, tag: tag});
      model_busy[tag] = 1'b0;
    end else begin
      spur_q.push_back(cyc + 1);
    end
    @(negedge c_clk);
    out_resp = 2'd0; out_data = '0; out_tag = 2'd0;
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({op_ready, req_cmd_in, req_data_in, req_tag_in, done_valid, done_resp, done_data, done_tag,
         timeout_valid, timeout_tag, spurious_err, outstanding} !== '0)
      $display("FAIL %s got ready=%b req=%h/%h/%0d done=%b/%0d/%h/%0d tmo=%b/%0d spur=%b out=%0d want all 0",
               name, op_ready, req_cmd_in, req_data_in, req_tag_in, done_valid, done_resp, done_data,
               done_tag, timeout_valid, timeout_tag, spurious_err, outstanding);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 1'b0; op_cmd = '0; op_a = '0; op_b = '0;
    out_resp = '0; out_data = '0; out_tag = '0;
    repeat (3) @(negedge c_clk);
    check_all_zero("reset_outputs");
    reset = 1'b0;
    @(negedge c_clk);
  endtask

  task automatic test_basic();
    logic [1:0] tag;
    int s1;
    issue(4'd1, 32'h5, 32'h3, tag, s1);
    n_checks++;
    if ({req_cmd_in, req_data_in, req_tag_in} !== {4'd1, 32'h5, 2'd0})
      $display("FAIL basic_send1 got cmd=%h data=%h tag=%0d want cmd=1 data=5 tag=0", req_cmd_in, req_data_in, req_tag_in);
    else n_pass++;
    @(negedge c_clk);
    n_checks++;
    if ({req_cmd_in, req_data_in, outstanding} !== {4'd0, 32'h3, 3'd1})
      $display("FAIL basic_send2 got cmd=%h data=%h outstanding=%0d want cmd=0 data=3 outstanding=1", req_cmd_in, req_data_in, outstanding);
    else n_pass++;
    respond(2'd1, 32'h8, 2'd0);
    n_checks++;
    if (outstanding !== 3'd0) $display("FAIL basic_outstanding got %0d want 0", outstanding);
    else n_pass++;
    @(negedge c_clk);
    n_checks++;
    if ({req_cmd_in, req_data_in, req_tag_in} !== '0)
      $display("FAIL basic_idle_req got cmd=%h data=%h tag=%0d want 0", req_cmd_in, req_data_in, req_tag_in);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  cmds [4] = '{4'd2, 4'd5, 4'd6, 4'hF};
    logic [1:0]  tag;
    int s1, prev;
    for (int i = 0; i < 4; i++) begin
      issue(cmds[i], 32'h100 + 32'(i), 32'h200 + 32'(i), tag, s1);
      n_checks++;
      if (req_tag_in !== 2'(i)) $display("FAIL b2b_tag%0d got %0d want %0d", i, req_tag_in, i);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (s1 - prev !== 2) $display("FAIL b2b_spacing%0d got %0d cycles want 2", i, s1 - prev);
        else n_pass++;
      end
      prev = s1;
    end
    @(negedge c_clk);
    n_checks++;
    if ({op_ready, outstanding} !== {1'b0, 3'd4})
      $display("FAIL b2b_full got op_ready=%b outstanding=%0d want op_ready=0 outstanding=4", op_ready, outstanding);
    else n_pass++;
    respond(2'd1, 32'h77, 2'd2);
    issue(4'd1, 32'hA, 32'hB, tag, s1);
    n_checks++;
    if ({req_tag_in, outstanding} !== {2'd2, 3'd4})
      $display("FAIL b2b_reuse got tag=%0d outstanding=%0d want tag=2 outstanding=4", req_tag_in, outstanding);
    else n_pass++;
    @(negedge c_clk);
    respond(2'd2, 32'hF00, 2'd3);
    respond(2'd1, 32'h10, 2'd0);
    respond(2'd3, 32'h20, 2'd1);
    respond(2'd1, 32'h30, 2'd2);
    @(negedge c_clk);
    n_checks++;
    if (outstanding !== 3'd0) $display("FAIL b2b_drain got outstanding=%0d want 0", outstanding);
    else n_pass++;
  endtask

  task automatic test_spurious();
    respond(2'd1, 32'h1234, 2'd3);
    @(negedge c_clk);
  endtask

  task automatic test_timeout();
    logic [1:0] tag;
    int s1;
    issue(4'd1, 32'h1, 32'h2, tag, s1);
    tmo_q.push_back('{due: s1 + T + 1, tag: tag});
    wait_until(s1 + T);
    n_checks++;
    if ({outstanding, timeout_valid} !== {3'd1, 1'b0})
      $display("FAIL tmo_before got outstanding=%0d timeout_valid=%b want 1/0", outstanding, timeout_valid);
    else n_pass++;
    @(negedge c_clk);
    model_busy[tag] = 1'b0;
    n_checks++;
    if (outstanding !== 3'd0) $display("FAIL tmo_after got outstanding=%0d want 0", outstanding);
    else n_pass++;
    @(negedge c_clk);
  endtask

  task automatic test_resp_at_timeout();
    logic [1:0] tag;
    int s1;
    issue(4'd2, 32'h9, 32'h4, tag, s1);
    wait_until(s1 + T);
    respond(2'd3, 32'hDEAD, tag);
    n_checks++;
    if ({timeout_valid, outstanding} !== {1'b0, 3'd0})
      $display("FAIL race_no_timeout got timeout_valid=%b outstanding=%0d want 0/0", timeout_valid, outstanding);
    else n_pass++;
    repeat (3) @(negedge c_clk);
  endtask

  task automatic test_reset_in_send2();
    logic [1:0] tag;
    int s1;
    issue(4'd1, 32'h11, 32'h22, tag, s1);
    @(negedge c_clk);
    reset = 1'b1;
    @(negedge c_clk);
    check_all_zero("reset_in_send2");
    model_busy = '0;
    reset = 1'b0;
    repeat (2) @(negedge c_clk);
    respond(2'd1, 32'h33, tag);
    @(negedge c_clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_spurious();
    test_timeout();
    test_resp_at_timeout();
    test_reset_in_send2();
    repeat (3) @(negedge c_clk);
    n_checks++;
    if (req_q.size() + done_q.size() + tmo_q.size() + spur_q.size() != 0)
      $display("FAIL leftover_events got req=%0d done=%0d tmo=%0d spur=%0d want all 0",
               req_q.size(), done_q.size(), tmo_q.size(), spur_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got time limit reached want finish");
    $fatal(1);
  end

endmodule

// File: doc/calc2_port_issuer.md
Name: calc2_port_issuer

Overview:
Upstream request issuer for one calc2_top request port. It accepts whole operations (cmd, operand A, operand B) over a valid/ready handshake and allocates a free 2-bit tag for each. It serialises each operation into the two-cycle calc2 request protocol and tracks every outstanding tag. It matches each returning response to its tag, reports completions, and reports two error cases: responses that never arrive (timeout) and responses carrying a tag that is not in flight. Four instances sit between the stimulus/host side and calc2_top, one per port.

Parameters:
DATA_W, 32, operand/result width
CMD_W, 4, command width
TAG_W, 2, tag width; NUM_TAGS = 2**TAG_W outstanding max
TIMEOUT, 64, cycles a tag may stay outstanding before it is declared lost (>=4)

Ports:
c_clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
op_valid  in  1  operation offered
op_ready  out  1  operation accepted when op_valid&&op_ready
op_cmd  in  CMD_W  calc2 command
op_a  in  DATA_W  operand 1
op_b  in  DATA_W  operand 2
req_cmd_in  out  CMD_W  to calc2 reqN_cmd_in
req_data_in  out  DATA_W  to calc2 reqN_data_in
req_tag_in  out  TAG_W  to calc2 reqN_tag_in
out_resp  in  2  from calc2 out_respN; 0 = no response
out_data  in  DATA_W  from calc2 out_dataN
out_tag  in  TAG_W  from calc2 out_tagN
done_valid  out  1  one-cycle completion pulse
done_resp  out  2  response code of the completion
done_data  out  DATA_W  result of the completion
done_tag  out  TAG_W  tag of the completion
timeout_valid  out  1  one-cycle pulse: tag freed without a response
timeout_tag  out  TAG_W  tag that timed out
spurious_err  out  1  one-cycle pulse: response received for a non-busy tag
outstanding  out  TAG_W+1  popcount of the busy mask

Behaviour:
- Reset: state IDLE, busy mask 0, all timers 0. All outputs 0, including op_ready. Reset mid-operation abandons the in-progress send and all outstanding tags; responses arriving later flag spurious_err.
- FSM with states IDLE, SEND1, SEND2. All request outputs are registered.
- op_ready = (state==IDLE || state==SEND2) && (free mask != 0).
- An accept in cycle N:
  - latches cmd, a, b;
  - allocates the lowest-index free tag and sets its busy bit at N+1;
  - goes to SEND1.
- SEND1 (N+1): req_cmd_in=cmd, req_data_in=a, req_tag_in=tag.
- SEND2 (N+2): req_cmd_in=0, req_data_in=b, req_tag_in=tag. An accept during SEND2 goes to SEND1; otherwise the FSM goes to IDLE.
- In IDLE, all req_* outputs are 0.
- Sustained throughput is one operation per 2 cycles.
- The free mask uses the registered busy bits. A tag freed in cycle N cannot be reallocated before N+1.
- Response path, for out_resp != 0 in cycle M:
  - tag busy: done_valid=1 with resp/data/tag at M+1, and the busy bit clears at M+1;
  - tag not busy: spurious_err=1 at M+1, no done_valid.
- A response and an allocation of a different tag in the same cycle are both honoured.
- Timer per tag: cleared on allocation, +1 each cycle while busy.
- When a timer reaches TIMEOUT with no response in that cycle: timeout_valid=1 and timeout_tag at the next cycle, and the tag is freed.
- Response in the same cycle as the timeout: the response wins, so done_valid and no timeout.
- Only one response per cycle is possible. If two tags reach TIMEOUT in the same cycle, the lowest tag is reported first; the others hold at TIMEOUT and report on later cycles.
- Command values are not policed. Invalid commands pass through and calc2_top's response code is forwarded unchanged.
- outstanding updates together with the busy mask.

Decomposition:
- calc2_pkg holds:
  - width constants CMD_W, DATA_W, TAG_W;
  - cmd enum: NOP=0, ADD=1, SUB=2, SHL=5, SHR=6;
  - resp enum: NONE=0, OK=1, OVF_INV=2, ERR=3.
- Sub-module calc2_tag_tracker holds the busy mask, per-tag timers, lowest-free allocation, free/timeout arbitration and the popcount. calc2_port_issuer keeps the FSM and the request output registers.

Test Plan:
- Reset, then accept ADD a=0x5 b=0x3 -> next cycle req_cmd_in=1, data=0x5, tag=0; following cycle cmd=0, data=0x3; outstanding=1. Drive out_resp=1, data=0x8, tag=0 -> done_valid pulse with resp=1, data=0x8, tag=0; outstanding=0.
- Offer 4 back-to-back ops -> tags 0,1,2,3 at 2-cycle spacing; op_ready=0 with outstanding=4. Respond tag 2 -> the next op gets tag 2.
- With 1 op outstanding on tag 0 and no response -> timeout_valid pulse, timeout_tag=0, TIMEOUT+1 cycles after SEND1; outstanding returns to 0.
- Response on tag 3 while idle -> spurious_err pulse, no done_valid.
- Response on tag 0 in the exact cycle its timer reaches TIMEOUT -> done_valid, no timeout_valid.
- Assert reset during SEND2 -> next cycle all outputs 0, state IDLE; a later response for the old tag -> spurious_err.
